dmem_be_ctrl: RTL and testbench

- Parametrised single-port data memory for the NovaEdge32 load/store path, successor to the fixed 32x1024 RAM.
- Adds byte/half/word access with byte enables and sign/zero extension for loads.
- Adds misalignment and range error reporting, a valid/ready request-response handshake and a configurable read latency.
- Sits between the core's memory stage and the on-chip data RAM; one outstanding request at a time.

---
 rtl/mem_pkg.sv | 59 +++++
 rtl/ram_be_array.sv | 30 +++
 rtl/dmem_be_ctrl.sv | 132 +++++++++++++
 tb/tb_dmem_be_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the NovaEdge32 data-memory path.
// Byte-lane logic is fixed at four 8-bit lanes of a 32-bit word.
package mem_pkg;

    localparam int LANES = 4;

    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    localparam logic [1:0] SIZE_RSV = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    function automatic logic [LANES-1:0] byte_enables(input logic [1:0] size,
                                                      input logic [1:0] lo);
        logic [LANES-1:0] be;
        be = '0;
        case (size)
            SIZE_B:  be = 4'b0001 << lo;
            SIZE_H:  be = 4'b0011 << lo;
            SIZE_W:  be = 4'b1111;
            default: be = '0;
        endcase
        return be;
    endfunction

    // Right-aligned store data is replicated so every enabled lane sees it.
    function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                                input logic [31:0] wdata);
        logic [31:0] d;
        d = wdata;
        case (size)
            SIZE_B:  d = {4{wdata[7:0]}};
            SIZE_H:  d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lo,
                                                input logic [1:0]  size,
                                                input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] d;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_B:  d = uns ? {24'b0, b} : {{24{b[7]}}, b};
            SIZE_H:  d = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: d = word;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ram_be_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// A read of the address being written returns the old contents.
module ram_be_array
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [LANES-1:0]  be,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we && be[i]) begin
                mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/dmem_be_ctrl.sv
// Load/store front end for the data RAM: one outstanding request, byte/half/word
// access with error screening at accept and sign/zero-extended load responses.
module dmem_be_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [1:0]        state_q, state_d;
    logic              accept;
    logic              acc_err;
    logic [ADDR_W-1:0] req_word;

    logic [ADDR_W-1:0] word_q;
    logic [1:0]        lo_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic              we_q;
    logic              err_q;

    logic              ram_we;
    logic [LANES-1:0]  ram_be;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    assign req_word = req_addr[ADDR_W+1:2];
    assign accept   = req_valid && (state_q == ST_IDLE) && !rst;

    always_comb begin
        acc_err = 1'b0;
        case (req_size)
            SIZE_H:   acc_err = req_addr[0];
            SIZE_W:   acc_err = |req_addr[1:0];
            SIZE_RSV: acc_err = 1'b1;
            default:  acc_err = 1'b0;
        endcase
        if ((req_addr >> (ADDR_W + 2)) != 32'd0) begin
            acc_err = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = (READ_LAT == 2) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            lo_q   <= 2'b00;
            size_q <= SIZE_B;
            uns_q  <= 1'b0;
            we_q   <= 1'b0;
            err_q  <= 1'b0;
        end else if (accept) begin
            word_q <= req_word;
            lo_q   <= req_addr[1:0];
            size_q <= req_size;
            uns_q  <= req_unsigned;
            we_q   <= req_we;
            err_q  <= acc_err;
        end
    end

    // Outside IDLE no write can occur, so re-reading the held word each cycle keeps
    // the response data stable while it waits for rsp_ready.
    assign ram_raddr = (state_q == ST_IDLE) ? req_word : word_q;
    assign ram_we    = accept && req_we && !acc_err;
    assign ram_be    = byte_enables(req_size, req_addr[1:0]);
    assign ram_wdata = store_lanes(req_size, req_wdata);

    ram_be_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (ram_be),
        .waddr (req_word),
        .raddr (ram_raddr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !we_q && !err_q) ?
                       load_extend(ram_rdata, lo_q, size_q, uns_q) : '0;

endmodule

// File: tb/tb_dmem_be_ctrl.sv
// Directed bench: two controllers (READ_LAT 1 and 2) share all inputs and are
// checked against hand-computed responses and latencies.
module tb_dmem_be_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    logic        a_req_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_rdata;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_be_ctrl #(.DATA_W(32), .DEPTH(1024), .READ_LAT(1)) dut_a (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (a_req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (a_rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (a_rsp_rdata),
        .rsp_err      (a_rsp_err)
    );

    dmem_be_ctrl #(.DATA_W(32), .DEPTH(1024), .READ_LAT(2)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (b_req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (b_rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (b_rsp_rdata),
        .rsp_err      (b_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request to both DUTs with rsp_ready high and check both responses.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err);
        logic        ga, gb, ea, eb;
        logic [31:0] rda, rdb;
        int          la, lb;
        check({tag, " readyA"}, {31'b0, a_req_ready}, 32'd1);
        check({tag, " readyB"}, {31'b0, b_req_ready}, 32'd1);
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        tick();
        req_valid = 1'b0;
        ga = 1'b0; gb = 1'b0; ea = 1'b0; eb = 1'b0;
        rda = '0; rdb = '0; la = 0; lb = 0;
        for (int c = 1; c <= 8 && !(ga && gb); c++) begin
            if (!ga && a_rsp_valid) begin
                ga = 1'b1; la = c; rda = a_rsp_rdata; ea = a_rsp_err;
            end
            if (!gb && b_rsp_valid) begin
                gb = 1'b1; lb = c; rdb = b_rsp_rdata; eb = b_rsp_err;
            end
            if (!(ga && gb)) tick();
        end
        tick();
        check({tag, " latA"}, la, 32'd1);
        check({tag, " latB"}, lb, 32'd2);
        check({tag, " rdataA"}, rda, exp_rd);
        check({tag, " rdataB"}, rdb, exp_rd);
        check({tag, " errA"}, {31'b0, ea}, {31'b0, exp_err});
        check({tag, " errB"}, {31'b0, eb}, {31'b0, exp_err});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_size = 2'b00; req_unsigned = 1'b0; req_wdata = '0; rsp_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset req_ready", {31'b0, a_req_ready}, 32'd1);
        check("reset rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
        check("reset rsp_rdata", a_rsp_rdata, 32'd0);
        check("reset rsp_err", {31'b0, a_rsp_err}, 32'd0);
        check("reset B rsp_valid", {31'b0, b_rsp_valid}, 32'd0);
        tick();

        // Word store/load and byte/half lane steering
        do_req("SW 10", 1, 32'h10, 2'b10, 0, 32'hDEADBEEF, 32'h0, 0);
        do_req("LW 10", 0, 32'h10, 2'b10, 0, 32'h0, 32'hDEADBEEF, 0);
        do_req("LH 10", 0, 32'h10, 2'b01, 0, 32'h0, 32'hFFFFBEEF, 0);
        do_req("SB 13", 1, 32'h13, 2'b00, 0, 32'hFFFFFF80, 32'h0, 0);
        do_req("LB 13", 0, 32'h13, 2'b00, 0, 32'h0, 32'hFFFFFF80, 0);
        do_req("LBU 13", 0, 32'h13, 2'b00, 1, 32'h0, 32'h00000080, 0);
        do_req("LW 10b", 0, 32'h10, 2'b10, 1, 32'h0, 32'h80ADBEEF, 0);
        do_req("LB 11", 0, 32'h11, 2'b00, 0, 32'h0, 32'hFFFFFFBE, 0);
        do_req("LBU 12", 0, 32'h12, 2'b00, 1, 32'h0, 32'h000000AD, 0);

        do_req("SW 20", 1, 32'h20, 2'b10, 0, 32'hAAAA5555, 32'h0, 0);
        do_req("SH 22", 1, 32'h22, 2'b01, 0, 32'hFFFF1234, 32'h0, 0);
        do_req("LH 22", 0, 32'h22, 2'b01, 0, 32'h0, 32'h00001234, 0);
        do_req("LH 21", 0, 32'h21, 2'b01, 0, 32'h0, 32'h0, 1);
        do_req("LW 20", 0, 32'h20, 2'b10, 0, 32'h0, 32'h12345555, 0);
        do_req("LHU 20", 0, 32'h20, 2'b01, 1, 32'h0, 32'h00005555, 0);

        // Error requests must not disturb word 0
        do_req("SW 0", 1, 32'h0, 2'b10, 0, 32'h11223344, 32'h0, 0);
        do_req("SW 1002", 1, 32'h1002, 2'b10, 0, 32'hCAFEF00D, 32'h0, 1);
        do_req("SW 1000", 1, 32'h1000, 2'b10, 0, 32'hCAFEF00D, 32'h0, 1);
        do_req("S rsv", 1, 32'h0, 2'b11, 0, 32'hCAFEF00D, 32'h0, 1);
        do_req("L rsv", 0, 32'h0, 2'b11, 0, 32'h0, 32'h0, 1);
        do_req("LW 12", 0, 32'h12, 2'b10, 0, 32'h0, 32'h0, 1);
        do_req("LW 0", 0, 32'h0, 2'b10, 0, 32'h0, 32'h11223344, 0);

        // Backpressure: response held, new requests ignored
        rsp_ready = 1'b0;
        req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_unsigned = 1'b0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        req_we = 1'b1; req_wdata = 32'h0; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold validA", {31'b0, a_rsp_valid}, 32'd1);
            check("hold rdataA", a_rsp_rdata, 32'h80ADBEEF);
            check("hold readyA", {31'b0, a_req_ready}, 32'd0);
            check("hold validB", {31'b0, b_rsp_valid}, 32'd1);
            check("hold rdataB", b_rsp_rdata, 32'h80ADBEEF);
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("release readyA", {31'b0, a_req_ready}, 32'd1);
        check("release validA", {31'b0, a_rsp_valid}, 32'd0);
        check("release readyB", {31'b0, b_req_ready}, 32'd1);
        do_req("LW 10c", 0, 32'h10, 2'b10, 0, 32'h0, 32'h80ADBEEF, 0);

        // Reset during a store response keeps the committed write
        rsp_ready = 1'b0;
        req_we = 1'b1; req_addr = 32'h40; req_size = 2'b10; req_wdata = 32'h55AA55AA;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("st resp validA", {31'b0, a_rsp_valid}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst drop validA", {31'b0, a_rsp_valid}, 32'd0);
        check("rst drop validB", {31'b0, b_rsp_valid}, 32'd0);
        check("rst drop readyA", {31'b0, a_req_ready}, 32'd1);
        rsp_ready = 1'b1;
        do_req("LW 40", 0, 32'h40, 2'b10, 0, 32'h0, 32'h55AA55AA, 0);

        // Reset beats a concurrent store request
        rst = 1'b1;
        req_we = 1'b1; req_addr = 32'h40; req_size = 2'b10; req_wdata = 32'h0BADF00D;
        req_valid = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 1'b0;
        tick();
        check("rst+req validA", {31'b0, a_rsp_valid}, 32'd0);
        check("rst+req validB", {31'b0, b_rsp_valid}, 32'd0);
        do_req("LW 40b", 0, 32'h40, 2'b10, 0, 32'h0, 32'h55AA55AA, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
